// File: rtl/dcache.sv
// dcache: direct-mapped, write-through, no-write-allocate data cache.
// Read hits are served combinationally. Read misses refill one whole line
// word by word. Every store goes straight to backing memory.
// Optional build macro DCACHE_STATS_EN adds hit_count_o / miss_count_o.
module dcache #(
  parameter int WIDTH       = 32,
  parameter int SETS        = 64,
  parameter int BLOCK_WORDS = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  input  logic             req_we_i,
  input  logic [WIDTH-1:0] req_addr_i,
  input  logic [WIDTH-1:0] req_wdata_i,
  input  logic [3:0]       req_wstrb_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             stall_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  output logic [3:0]       mem_wstrb_o,
  input  logic             mem_ready_i,
  input  logic [WIDTH-1:0] mem_rdata_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]      hit_count_o,
  output logic [31:0]      miss_count_o
`endif
);
  localparam int OFF_W  = $clog2(BLOCK_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int IDX_LO = OFF_W + 2;
  localparam int TAG_LO = IDX_LO + IDX_W;
  localparam int TAG_W  = WIDTH - TAG_LO;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_e;

  // Storage: only the valid bits are reset.
  logic [WIDTH-1:0] data_q [SETS][BLOCK_WORDS];
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [SETS-1:0]  valid_q;

  state_e           state_q, state_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;

  // Request-side address fields (live in IDLE).
  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             req_hit;
  // Latched-address fields (used in REFILL/WRITE).
  logic [OFF_W-1:0] lat_off;
  logic [IDX_W-1:0] lat_idx;
  logic [TAG_W-1:0] lat_tag;
  logic             lat_hit;

  logic refill_wr, merge_wr, set_line, lookup;
  logic unused_bits;

  assign req_off = req_addr_i[IDX_LO-1:2];
  assign req_idx = req_addr_i[TAG_LO-1:IDX_LO];
  assign req_tag = req_addr_i[WIDTH-1:TAG_LO];
  assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  assign lat_off = addr_q[IDX_LO-1:2];
  assign lat_idx = addr_q[TAG_LO-1:IDX_LO];
  assign lat_tag = addr_q[WIDTH-1:TAG_LO];
  assign lat_hit = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);

  // Byte offsets are ignored: all accesses are word aligned.
  assign unused_bits = ^{req_addr_i[1:0], addr_q[1:0]};

  // Next-state and output decode; outputs idle at zero outside active states.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rdata_o     = '0;
    stall_o     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    refill_wr   = 1'b0;
    merge_wr    = 1'b0;
    set_line    = 1'b0;
    lookup      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          lookup = 1'b1;
          if (req_we_i) begin
            stall_o = 1'b1;
            addr_d  = req_addr_i;
            wdata_d = req_wdata_i;
            wstrb_d = req_wstrb_i;
            state_d = WRITE;
          end else if (req_hit) begin
            rdata_o = data_q[req_idx][req_off];
          end else begin
            stall_o = 1'b1;
            addr_d  = req_addr_i;
            cnt_d   = '0;
            state_d = REFILL;
          end
        end
      end
      REFILL: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {addr_q[WIDTH-1:IDX_LO], cnt_q, 2'b00};
        if (mem_ready_i) begin
          refill_wr = 1'b1;
          cnt_d     = cnt_q + OFF_W'(1);
          if (cnt_q == OFF_W'(BLOCK_WORDS - 1)) begin
            set_line = 1'b1;
            cnt_d    = '0;
            state_d  = IDLE;
          end
        end
      end
      WRITE: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {addr_q[WIDTH-1:2], 2'b00};
        mem_wdata_o = wdata_q;
        mem_wstrb_o = wstrb_q;
        if (mem_ready_i) begin
          // Release the pipeline in the completing cycle so the store retires.
          stall_o  = 1'b0;
          merge_wr = lat_hit;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and valid bits; reset drops any partial refill.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      if (set_line) valid_q[lat_idx] <= 1'b1;
    end
  end

  // Data/tag arrays: refill writes a whole word, store hits merge strobed bytes.
  always_ff @(posedge clk_i) begin
    if (refill_wr) begin
      data_q[lat_idx][cnt_q] <= mem_rdata_i;
    end else if (merge_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) data_q[lat_idx][lat_off][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
    if (set_line) tag_q[lat_idx] <= lat_tag;
  end

`ifdef DCACHE_STATS_EN
  // One count per IDLE-state lookup, loads and stores alike.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_count_o  <= '0;
      miss_count_o <= '0;
    end else if (lookup) begin
      if (req_hit) hit_count_o  <= hit_count_o + 32'd1;
      else         miss_count_o <= miss_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache.sv
// Scoreboard bench for dcache: the driver pushes expected responses from a
// line-level reference model; a monitor checks memory traffic and retirements.
module tb_dcache;
  localparam int SETS = 64;
  localparam int BW   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic [31:0] rdata;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  dcache #(.WIDTH(32), .SETS(SETS), .BLOCK_WORDS(BW)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .rdata_o(rdata), .stall_o(stall),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb),
    .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata)
`ifdef DCACHE_STATS_EN
    , .hit_count_o(hit_count), .miss_count_o(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE00;
  endfunction

  // Backing memory seen by the DUT, and the bench's own reference copy.
  logic [31:0] bk_mem  [int];
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] bk_rd(input logic [31:0] a);
    return bk_mem.exists(int'(a >> 2)) ? bk_mem[int'(a >> 2)] : init_word(a & 32'hFFFF_FFFC);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(int'(a >> 2)) ? ref_mem[int'(a >> 2)] : init_word(a & 32'hFFFF_FFFC);
  endfunction

  task automatic preset(input logic [31:0] a, input logic [31:0] v);
    bk_mem[int'(a >> 2)]  = v;
    ref_mem[int'(a >> 2)] = v;
  endtask

  // Reference model: which memory block each set holds (-1 = empty).
  typedef struct {
    logic        we;
    logic        hit;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  wstrb;
  } exp_t;

  exp_t q[$];
  int   cached [SETS];
  int   exp_hits = 0, exp_miss = 0;

  task automatic model_reset();
    foreach (cached[i]) cached[i] = -1;
    exp_hits = 0;
    exp_miss = 0;
    q.delete();
  endtask

  task automatic push_exp(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] st);
    exp_t e;
    logic [31:0] wa, w;
    int blk, idx;
    wa  = addr & 32'hFFFF_FFFC;
    blk = int'(wa / (BW * 4));
    idx = blk % SETS;
    e.we = we; e.addr = wa; e.wdata = wd; e.wstrb = st; e.rdata = '0;
    e.hit = (cached[idx] == blk);
    if (we) begin
      w = ref_rd(wa);
      for (int b = 0; b < 4; b++) if (st[b]) w[8*b +: 8] = wd[8*b +: 8];
      ref_mem[int'(wa >> 2)] = w;
      if (e.hit) exp_hits++; else exp_miss++;
    end else begin
      // A load miss is looked up twice: the miss, then the retry that hits.
      if (!e.hit) begin cached[idx] = blk; exp_miss++; end
      exp_hits++;
      e.rdata = ref_rd(wa);
    end
    q.push_back(e);
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] st);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = st;
  endtask

  task automatic wait_done();
    int cyc = 0;
    do begin @(negedge clk); cyc++; end while (stall && cyc < 300);
    if (stall) begin
      checks++; errors++;
      $display("FAIL retire_timeout: stall still %b after %0d cycles", stall, cyc);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] st);
    push_exp(we, addr, wd, st);
    drive(we, addr, wd, st);
    wait_done();
  endtask

  task automatic check_idle_outputs(input string tag);
    check32({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    check32({tag, "_stall"}, 32'(stall), 32'd0);
    check32({tag, "_rdata"}, rdata, 32'd0);
    check32({tag, "_mem_addr"}, mem_addr, 32'd0);
`ifdef DCACHE_STATS_EN
    check32({tag, "_hit_count"}, hit_count, 32'd0);
    check32({tag, "_miss_count"}, miss_count, 32'd0);
`endif
  endtask

  // Memory responder: random ready latency, stores applied on handshake.
  logic        hs_we = 1'b0;
  logic [31:0] hs_addr = '0, hs_data = '0;
  logic [3:0]  hs_strb = '0;

  always @(negedge clk) begin
    hs_we   = mem_req && mem_ready && mem_we;
    hs_addr = mem_addr;
    hs_data = mem_wdata;
    hs_strb = mem_wstrb;
  end

  always @(posedge clk) begin
    logic [31:0] w;
    if (!rst && hs_we) begin
      w = bk_rd(hs_addr);
      for (int b = 0; b < 4; b++) if (hs_strb[b]) w[8*b +: 8] = hs_data[8*b +: 8];
      bk_mem[int'(hs_addr >> 2)] = w;
    end
    #1;
    if (rst || !mem_req) begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
    end else begin
      mem_ready = ($urandom_range(0, 2) != 0);
      mem_rdata = (mem_ready && !mem_we) ? bk_rd(mem_addr) : $urandom;
    end
  end

  // Monitor: checks memory traffic against the head transaction and pops it
  // when the DUT retires the access (req_valid with stall low).
  int          rd_hs = 0, wr_hs = 0, st_cyc = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      rd_hs = 0; wr_hs = 0; st_cyc = 0; pend = 1'b0;
    end else begin
      if (pend) begin
        check32("req_held", 32'(mem_req), 32'd1);
        check32("addr_stable", mem_addr, pend_addr);
      end
      pend      = mem_req && !mem_ready;
      pend_addr = mem_addr;
      if (mem_req && mem_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL stray_mem_access: addr %h we %b with no open request", mem_addr, mem_we);
        end else if (mem_we) begin
          check32("wr_is_store", 32'(q[0].we), 32'd1);
          check32("wr_addr", mem_addr, q[0].addr);
          check32("wr_data", mem_wdata, q[0].wdata);
          check32("wr_strb", 32'(mem_wstrb), 32'(q[0].wstrb));
          wr_hs++;
        end else begin
          check32("refill_addr", mem_addr,
                  (q[0].addr & ~32'(BW * 4 - 1)) + 32'(4 * rd_hs));
          rd_hs++;
        end
      end
      if (req_valid && stall) st_cyc++;
      if (req_valid && !stall) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL stray_retire: addr %h retired with empty scoreboard", req_addr);
        end else begin
          e = q.pop_front();
          if (!e.we) begin
            check32("load_data", rdata, e.rdata);
            check32("refill_words", rd_hs, e.hit ? 0 : BW);
            if (e.hit) check32("hit_no_stall", st_cyc, 0);
          end else begin
            check32("store_refills", rd_hs, 0);
          end
          check32("mem_writes", wr_hs, e.we ? 1 : 0);
        end
        rd_hs = 0; wr_hs = 0; st_cyc = 0;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    model_reset();
    @(posedge clk); #1;
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] a, wd;
    int n;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Directed: refill, hit, store hit merge, store miss, conflict eviction.
    preset(32'h100, 32'h11); preset(32'h104, 32'h22);
    preset(32'h108, 32'h33); preset(32'h10C, 32'h44);
    issue(1'b0, 32'h100, '0, '0);
    issue(1'b0, 32'h108, '0, '0);
    issue(1'b1, 32'h104, 32'hAABB_CCDD, 4'b0011);
    issue(1'b0, 32'h104, '0, '0);
    issue(1'b1, 32'h400, 32'h1234_5678, 4'b1111);
    issue(1'b0, 32'h400, '0, '0);
    issue(1'b0, 32'h100, '0, '0);
    issue(1'b0, 32'h100 + SETS * BW * 4, '0, '0);
    issue(1'b0, 32'h100, '0, '0);
`ifdef DCACHE_STATS_EN
    check32("stats_hits_directed", hit_count, 32'(exp_hits));
    check32("stats_miss_directed", miss_count, 32'(exp_miss));
`endif

    // Reset in the middle of a refill: the line must refill again afterwards.
    do_reset();
    push_exp(1'b0, 32'h100, '0, '0);
    drive(1'b0, 32'h100, '0, '0);
    n = 0;
    for (int c = 0; c < 200 && n < 2; c++) begin
      @(negedge clk);
      if (mem_req && mem_ready && !mem_we) n++;
    end
    check32("partial_refill_reached", n, 2);
    @(posedge clk); #1;
    do_reset();
    issue(1'b0, 32'h100, '0, '0);

    // Random mix over a few sets and tags so hits, misses and evictions all occur.
    for (int i = 0; i < 400; i++) begin
      a  = ((32'($urandom_range(0, 3)) * SETS + 32'($urandom_range(0, 7))) * BW * 4)
           + 32'($urandom_range(0, 15));
      wd = $urandom;
      if ($urandom_range(0, 2) == 0) issue(1'b1, a, wd, 4'($urandom_range(1, 15)));
      else                           issue(1'b0, a, '0, '0);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    repeat (3) @(negedge clk);
    check32("scoreboard_drained", q.size(), 0);
`ifdef DCACHE_STATS_EN
    check32("stats_hits_final", hit_count, 32'(exp_hits));
    check32("stats_miss_final", miss_count, 32'(exp_miss));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit (errors so far %0d)", errors);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
